// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b encoder for one DVI/HDMI colour channel: input register, transition-minimise stage,
// DC-balance stage, optional output register. Define TMDS_DISP_MON_EN to expose the disparity.
module tmds_channel_encoder #(
  parameter int unsigned REG_OUT = 0
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       vde,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  output logic [9:0] tmds_out
`ifdef TMDS_DISP_MON_EN
  ,
  output logic signed [4:0] disp_mon
`endif
);

  localparam logic [9:0] CtrlSym00 = 10'h354;
  localparam logic [9:0] CtrlSym01 = 10'h0AB;
  localparam logic [9:0] CtrlSym10 = 10'h154;
  localparam logic [9:0] CtrlSym11 = 10'h2AB;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b000, v[i]};
    end
    return s;
  endfunction

  // Input capture
  logic       in_vde_q;
  logic [7:0] in_din_q;
  logic [1:0] in_ctl_q;

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      in_vde_q <= 1'b0;
      in_din_q <= '0;
      in_ctl_q <= '0;
    end else begin
      in_vde_q <= vde;
      in_din_q <= din;
      in_ctl_q <= {c1, c0};
    end
  end

  // Stage 1: transition-minimised word q_m
  logic [3:0] n1;
  logic       use_xnor;
  logic [8:0] qm_d;

  always_comb begin
    n1       = popcount8(in_din_q);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !in_din_q[0]);
    qm_d     = '0;
    qm_d[0]  = in_din_q[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ in_din_q[i]) : (qm_d[i-1] ^ in_din_q[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  logic [8:0] s1_qm_q;
  logic       s1_vde_q;
  logic [1:0] s1_ctl_q;

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      s1_qm_q  <= '0;
      s1_vde_q <= 1'b0;
      s1_ctl_q <= '0;
    end else begin
      s1_qm_q  <= qm_d;
      s1_vde_q <= in_vde_q;
      s1_ctl_q <= in_ctl_q;
    end
  end

  // Stage 2: DC balance against the running disparity
  logic        [3:0] n1q;
  logic        [3:0] n0q;
  logic signed [4:0] diff;
  logic signed [4:0] bias_hi;
  logic signed [4:0] bias_lo;
  logic        [9:0] sym_d;
  logic        [9:0] sym_q;
  logic signed [4:0] cnt_d;
  logic signed [4:0] cnt_q;

  always_comb begin
    n1q     = popcount8(s1_qm_q[7:0]);
    n0q     = 4'd8 - n1q;
    diff    = $signed({1'b0, n1q} - {1'b0, n0q});
    bias_hi = s1_qm_q[8] ? 5'sd2 : 5'sd0;
    bias_lo = s1_qm_q[8] ? 5'sd0 : 5'sd2;
    sym_d   = CtrlSym00;
    cnt_d   = cnt_q;
    if (!s1_vde_q) begin
      unique case (s1_ctl_q)
        2'b00:   sym_d = CtrlSym00;
        2'b01:   sym_d = CtrlSym01;
        2'b10:   sym_d = CtrlSym10;
        default: sym_d = CtrlSym11;
      endcase
      cnt_d = 5'sd0;
    end else if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
      sym_d = {~s1_qm_q[8], s1_qm_q[8], s1_qm_q[8] ? s1_qm_q[7:0] : ~s1_qm_q[7:0]};
      cnt_d = s1_qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
    end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) || ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
      sym_d = {1'b1, s1_qm_q[8], ~s1_qm_q[7:0]};
      cnt_d = cnt_q + bias_hi - diff;
    end else begin
      sym_d = {1'b0, s1_qm_q[8], s1_qm_q[7:0]};
      cnt_d = cnt_q + diff - bias_lo;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      sym_q <= CtrlSym00;
      cnt_q <= 5'sd0;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [9:0] out_q;
    always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
        out_q <= CtrlSym00;
      end else begin
        out_q <= sym_q;
      end
    end
    assign tmds_out = out_q;
`ifdef TMDS_DISP_MON_EN
    logic signed [4:0] mon_q;
    always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
        mon_q <= 5'sd0;
      end else begin
        mon_q <= cnt_q;
      end
    end
    assign disp_mon = mon_q;
`endif
  end else begin : g_no_reg_out
    assign tmds_out = sym_q;
`ifdef TMDS_DISP_MON_EN
    assign disp_mon = cnt_q;
`endif
  end

`ifdef TMDS_DISP_MON_EN
`ifndef SYNTHESIS
  always @(posedge pixel_clk) begin
    if (reset) begin
      assert ((cnt_q <= 5'sd10) && (cnt_q >= -5'sd10))
      else $error("tmds disparity out of range: %0d", cnt_q);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Randomised self-checking bench for tmds_channel_encoder; runs REG_OUT=0 and REG_OUT=1 side by
// side against a behavioural encoder/decoder model.
module tb_tmds_channel_encoder;

  logic       pixel_clk;
  logic       reset;
  logic       vde;
  logic [7:0] din;
  logic       c0;
  logic       c1;
  logic [9:0] out0;
  logic [9:0] out1;
`ifdef TMDS_DISP_MON_EN
  logic [4:0] mon0;
  logic [4:0] mon1;
`endif

  tmds_channel_encoder #(.REG_OUT(0)) u_dut0 (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .vde       (vde),
    .din       (din),
    .c0        (c0),
    .c1        (c1),
    .tmds_out  (out0)
`ifdef TMDS_DISP_MON_EN
    ,
    .disp_mon  (mon0)
`endif
  );

  tmds_channel_encoder #(.REG_OUT(1)) u_dut1 (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .vde       (vde),
    .din       (din),
    .c0        (c0),
    .c1        (c1),
    .tmds_out  (out1)
`ifdef TMDS_DISP_MON_EN
    ,
    .disp_mon  (mon1)
`endif
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic [9:0] sym;
    logic [4:0] cnt;
    logic       vde;
    logic [7:0] din;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt;
  int   n_cmp;
  int   n_bad;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder straight from the TMDS rules, tracking disparity as a plain integer.
  task automatic model(input logic v, input logic [1:0] c, input logic [7:0] d,
                       output logic [9:0] sym);
    int         ones;
    int         df;
    bit         xn;
    logic [7:0] qm;
    logic       qm8;
    if (!v) begin
      case (c)
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
      m_cnt = 0;
    end else begin
      ones  = $countones(d);
      xn    = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm8 = !xn;
      df  = 2 * $countones(qm) - 8;
      if (m_cnt == 0 || df == 0) begin
        sym   = {~qm8, qm8, qm8 ? qm : ~qm};
        m_cnt = qm8 ? m_cnt + df : m_cnt - df;
      end else if ((m_cnt > 0 && df > 0) || (m_cnt < 0 && df < 0)) begin
        sym   = {1'b1, qm8, ~qm};
        m_cnt = m_cnt + (qm8 ? 2 : 0) - df;
      end else begin
        sym   = {1'b0, qm8, qm};
        m_cnt = m_cnt + df - (qm8 ? 0 : 2);
      end
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  // After reset every pipeline stage holds a blank 00 control slot.
  task automatic prefill();
    exp_t e;
    exp_q.delete();
    m_cnt = 0;
    e.sym = 10'h354;
    e.cnt = 5'd0;
    e.vde = 1'b0;
    e.din = 8'h00;
    repeat (3) exp_q.push_back(e);
  endtask

  task automatic step(input logic v, input logic [1:0] c, input logic [7:0] d);
    exp_t       e;
    exp_t       e2;
    exp_t       e3;
    logic [9:0] s;
    vde = v;
    {c1, c0} = c;
    din = d;
    model(v, c, d, s);
    e.sym = s;
    e.cnt = 5'(m_cnt);
    e.vde = v;
    e.din = d;
    exp_q.push_back(e);
    if (exp_q.size() > 4) void'(exp_q.pop_front());
    @(posedge pixel_clk);
    #1;
    e2 = exp_q[$-2];
    e3 = exp_q[$-3];
    check_eq("sym_lat2", {6'd0, out0}, {6'd0, e2.sym});
    check_eq("sym_lat3", {6'd0, out1}, {6'd0, e3.sym});
    if (e2.vde) check_eq("decode", {8'd0, decode(out0)}, {8'd0, e2.din});
`ifdef TMDS_DISP_MON_EN
    check_eq("mon_lat2", {11'd0, mon0}, {11'd0, e2.cnt});
    check_eq("mon_lat3", {11'd0, mon1}, {11'd0, e3.cnt});
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check_eq(tag, {6'd0, out0}, 16'h0354);
    check_eq(tag, {6'd0, out1}, 16'h0354);
`ifdef TMDS_DISP_MON_EN
    check_eq(tag, {11'd0, mon0}, 16'h0000);
    check_eq(tag, {11'd0, mon1}, 16'h0000);
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_cnt = 0;
    reset = 1'b0;
    vde   = 1'b0;
    din   = 8'h00;
    c0    = 1'b0;
    c1    = 1'b0;

    // Reset held while inputs toggle
    repeat (6) begin
      vde = 1'($urandom);
      din = 8'($urandom);
      {c1, c0} = 2'($urandom);
      @(posedge pixel_clk);
      #1;
      check_reset_state("reset_hold");
    end
    reset = 1'b1;
    prefill();

    // All four control codes, then flush
    for (int k = 0; k < 4; k++) step(1'b0, 2'(k), 8'($urandom));
    repeat (3) step(1'b0, 2'b00, 8'h00);

    // DC balance from cnt=0, then the XNOR path
    step(1'b1, 2'b00, 8'h00);
    step(1'b1, 2'b00, 8'h00);
    step(1'b0, 2'b00, 8'h00);
    step(1'b1, 2'b00, 8'hFF);
    step(1'b1, 2'b00, 8'hFF);
    repeat (3) step(1'b0, 2'b01, 8'h00);

    // One active line followed by blanking
    for (int k = 0; k < 640; k++) step(1'b1, 2'($urandom), 8'($urandom));
    repeat (4) step(1'b0, 2'($urandom), 8'($urandom));

    // Long mixed stream with sporadic blanking
    for (int k = 0; k < 20000; k++) begin
      step(($urandom_range(0, 15) != 0), 2'($urandom), 8'($urandom));
    end

    // Mid-line reset: asynchronous clear, then restart from cnt=0
    for (int k = 0; k < 20; k++) step(1'b1, 2'b00, 8'($urandom));
    reset = 1'b0;
    #1;
    check_reset_state("reset_async");
    repeat (3) begin
      vde = 1'b1;
      din = 8'($urandom);
      @(posedge pixel_clk);
      #1;
      check_reset_state("reset_mid");
    end
    reset = 1'b1;
    prefill();
    step(1'b1, 2'b00, 8'h00);
    step(1'b1, 2'b00, 8'h00);
    repeat (4) step(1'b0, 2'b00, 8'h00);
    for (int k = 0; k < 200; k++) step(1'b1, 2'($urandom), 8'($urandom));
    repeat (4) step(1'b0, 2'b10, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
